// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the handshake FSM state types
// used by axi_lite_slave_regs and its register bank.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      WR_IDLE,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_e;

   // Expands a 4-bit byte strobe into a 32-bit bit mask.
   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] mask;
      mask = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) begin
            mask[8*b +: 8] = 8'hFF;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register bank for axi_lite_slave_regs: byte-strobed writes, per-register write
// pulse and a combinational read mux (indices with no register read as zero).
module axi_lite_reg_bank
   import axi_lite_pkg::*;
#(
   parameter int unsigned C_NUM_REGS = 8,
   parameter int unsigned IDX_W      = 30
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    we_i,
   input  logic [IDX_W-1:0]        wr_idx_i,
   input  logic [31:0]             wdata_i,
   input  logic [3:0]              wstrb_i,
   input  logic [IDX_W-1:0]        rd_idx_i,
   output logic [31:0]             rd_data_o,
   output logic [32*C_NUM_REGS-1:0] reg_out_o,
   output logic [C_NUM_REGS-1:0]   wr_pulse_o
);

   logic [31:0]           regs_q [C_NUM_REGS];
   logic [31:0]           regs_d [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] pulse_q;
   logic [C_NUM_REGS-1:0] pulse_d;
   logic [31:0]           wmask;

   assign wmask = strb_to_mask(wstrb_i);

   always_comb begin
      regs_d  = regs_q;
      pulse_d = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
         if (we_i && (wr_idx_i == IDX_W'(i))) begin
            regs_d[i]  = (regs_q[i] & ~wmask) | (wdata_i & wmask);
            pulse_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q  <= '{default: '0};
         pulse_q <= '0;
      end else begin
         regs_q  <= regs_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
         if (rd_idx_i == IDX_W'(i)) begin
            rd_data_o = regs_q[i];
         end
      end
   end

   always_comb begin
      reg_out_o = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
         reg_out_o[32*i +: 32] = regs_q[i];
      end
   end

   assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing C_NUM_REGS 32-bit registers with independent write/read FSMs.
// Define AXI_LITE_SLAVE_ERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_NUM_REGS         = 8
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [32*C_NUM_REGS-1:0]        REG_OUT,
   output logic [C_NUM_REGS-1:0]           REG_WR_PULSE
);

   localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   wr_state_e         wr_state_q;
   logic              aw_held_q;
   logic              w_held_q;
   logic [IDX_W-1:0]  wr_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;

   rd_state_e         rd_state_q;
   logic              rvalid_q;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;

   logic              awready;
   logic              wready;
   logic              arready;
   logic              wr_commit;
   logic              bank_we;
   logic [1:0]        wr_resp;
   logic [1:0]        rd_resp;
   logic [IDX_W-1:0]  rd_idx;
   logic [31:0]       rd_data;

   logic              unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign awready   = ~aw_held_q & ~bvalid_q;
   assign wready    = ~w_held_q & ~bvalid_q;
   assign arready   = (rd_state_q == RD_IDLE);
   assign wr_commit = aw_held_q & w_held_q & (wr_state_q == WR_IDLE);
   assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef AXI_LITE_SLAVE_ERR_EN
   logic wr_in_range;
   logic rd_in_range;
   assign wr_in_range = (wr_idx_q < IDX_W'(C_NUM_REGS));
   assign rd_in_range = (rd_idx < IDX_W'(C_NUM_REGS));
   assign bank_we     = wr_commit & wr_in_range;
   assign wr_resp     = wr_in_range ? RESP_OKAY : RESP_SLVERR;
   assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
   // Out-of-range indices match no register in the bank, so writes drop and reads give 0.
   assign bank_we = wr_commit;
   assign wr_resp = RESP_OKAY;
   assign rd_resp = RESP_OKAY;
`endif

   axi_lite_reg_bank #(
      .C_NUM_REGS (C_NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk_i      (S_AXI_ACLK),
      .rst_i      (S_AXI_ARESET),
      .we_i       (bank_we),
      .wr_idx_i   (wr_idx_q),
      .wdata_i    (wdata_q),
      .wstrb_i    (wstrb_q),
      .rd_idx_i   (rd_idx),
      .rd_data_o  (rd_data),
      .reg_out_o  (REG_OUT),
      .wr_pulse_o (REG_WR_PULSE)
   );

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         wr_state_q <= WR_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         wr_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               if (aw_held_q && w_held_q) begin
                  bvalid_q   <= 1'b1;
                  bresp_q    <= wr_resp;
                  wr_state_q <= WR_RESP;
               end
               if (awready && S_AXI_AWVALID) begin
                  aw_held_q <= 1'b1;
                  wr_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
               end
               if (wready && S_AXI_WVALID) begin
                  w_held_q <= 1'b1;
                  wdata_q  <= S_AXI_WDATA;
                  wstrb_q  <= S_AXI_WSTRB;
               end
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_q   <= 1'b0;
                  aw_held_q  <= 1'b0;
                  w_held_q   <= 1'b0;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: wr_state_q <= WR_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rd_state_q <= RD_IDLE;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (S_AXI_ARVALID) begin
                  rdata_q    <= rd_data;
                  rresp_q    <= rd_resp;
                  rvalid_q   <= 1'b1;
                  rd_state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (S_AXI_RREADY) begin
                  rvalid_q   <= 1'b0;
                  rd_state_q <= RD_IDLE;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = wready;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule
